// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engines: FSM state encoding,
// default widths and the idle levels driven onto the pads.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned SPI_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } spi_state_t;

    localparam logic SCLK_RST = 1'b0;
    localparam logic MOSI_RST = 1'b1;
    localparam logic CS_N_RST = 1'b1;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer for SPI clock generation. A load primes the counter
// with the divider value; while run is high it counts down to zero and
// expire is high in the cycle the count sits at zero, so one half period
// lasts load_val+1 cycles. A load takes priority over counting.
module spi_half_period_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Down-counter: reload on request, otherwise count towards zero and hold there
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/sd_spi_engine.sv
// Byte-serial SPI master shift engine (mode 0, MSB first) for the SD-card
// path. Accepts transmit words from the register file, drives SCLK/MOSI,
// samples MISO on rising SCLK and returns each received word with a
// one-cycle rx_valid pulse.
// Optional build macro: SD_SPI_ENGINE_LOOPBACK_EN adds a loopback input
// that routes MOSI back into the receive path and holds chip select off.
module sd_spi_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned DIV_W  = SPI_DIV_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cs_assert,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    spi_state_t        state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rx_shift;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bitcnt;

    logic              accept;
    logic              timer_run;
    logic              timer_load;
    logic [DIV_W-1:0]  timer_val;
    logic              half_expire;
    logic              miso_in;

    // MOSI is the shift register MSB; the register refills with ones so the
    // line idles high between words without a separate output flop.
    assign spi_mosi = shift_reg[DATA_W-1];

    // Handshake and timer control derived from the registered state
    always_comb begin
        accept     = (state == IDLE) && tx_valid && tx_ready;
        timer_run  = (state == LOW) || (state == HIGH);
        timer_load = accept || (timer_run && half_expire);
        timer_val  = accept ? clk_div : div_q;
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
        miso_in    = loopback ? spi_mosi : spi_miso;
`else
        miso_in    = spi_miso;
`endif
    end

    spi_half_period_timer #(
        .CNT_W (DIV_W)
    ) u_half_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .run      (timer_run),
        .load_val (timer_val),
        .expire   (half_expire)
    );

    // Chip select follows the register-file request one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            spi_cs_n <= CS_N_RST;
        end else begin
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
            spi_cs_n <= loopback ? 1'b1 : ~cs_assert;
`else
            spi_cs_n <= ~cs_assert;
`endif
        end
    end

    // Transfer FSM: accept a word, generate SCLK half periods, shift and sample
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            spi_sclk  <= SCLK_RST;
            shift_reg <= {DATA_W{MOSI_RST}};
            rx_shift  <= '0;
            div_q     <= '0;
            bitcnt    <= '0;
        end else begin
            rx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (accept) begin
                        shift_reg <= tx_data;
                        div_q     <= clk_div;
                        bitcnt    <= BIT_W'(DATA_W);
                        spi_sclk  <= 1'b0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (half_expire) begin
                        spi_sclk <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso_in};
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (half_expire) begin
                        spi_sclk <= 1'b0;
                        bitcnt   <= bitcnt - BIT_W'(1);
                        if (bitcnt == BIT_W'(1)) begin
                            rx_data   <= rx_shift;
                            rx_valid  <= 1'b1;
                            shift_reg <= {DATA_W{MOSI_RST}};
                            state     <= DONE;
                        end else begin
                            shift_reg <= {shift_reg[DATA_W-2:0], MOSI_RST};
                            state     <= LOW;
                        end
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Self-checking bench for sd_spi_engine: a mode-0 SPI slave model, an SCLK
// timing monitor and per-scenario tasks compared against latency and data
// expectations computed from the transfer rules.
module tb_sd_spi_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] clk_div = '0;
    logic       cs_assert = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = '0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    sd_spi_engine #(
        .DATA_W (8),
        .DIV_W  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clk_div   (clk_div),
        .cs_assert (cs_assert),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Slave model: presents its word MSB first, advancing on each SCLK fall
    logic [7:0] slave_word = 8'hFF;
    int fall_total = 0;
    int fall_base = 0;
    always @(negedge spi_sclk) fall_total++;
    always_comb begin
        spi_miso = 1'b1;
        if ((fall_total - fall_base) < 8)
            spi_miso = slave_word[7 - (fall_total - fall_base)];
    end

    // SCLK monitor: MOSI at each rise and half-period lengths inside a word
    int rise_total = 0;
    int rise_base = 0;
    int bad_total = 0;
    int bad_base = 0;
    int exp_half = 1;
    int run_len = 0;
    logic prev_sclk = 1'b0;
    logic [63:0] mosi_hist = '0;
    always @(negedge clock) begin
        if (spi_sclk !== prev_sclk) begin
            if (spi_sclk === 1'b1) begin
                if (rise_total != rise_base && run_len != exp_half) bad_total++;
                rise_total++;
                mosi_hist = {mosi_hist[62:0], spi_mosi};
            end else begin
                if (run_len != exp_half) bad_total++;
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_sclk = spi_sclk;
    end

    task automatic mark_word(input logic [7:0] slv, input int half);
        slave_word = slv;
        fall_base  = fall_total;
        rise_base  = rise_total;
        bad_base   = bad_total;
        exp_half   = half;
    endtask

    // Offer one word and wait for its completion; optionally rewrite clk_div mid-word
    task automatic send_word(input logic [7:0] tx, input logic [7:0] div, input logic [7:0] slv,
                             input int chg_at, input logic [7:0] chg_div,
                             output logic [7:0] rx, output int lat, output logic [7:0] mosi_w,
                             output int rises, output int bad, output bit tmo);
        int t;
        int a;
        tmo = 1'b0; rx = '0; lat = 0; mosi_w = '0; rises = 0; bad = 0;
        tx_valid = 1'b1; tx_data = tx; clk_div = div;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        if (tx_ready !== 1'b1) begin tmo = 1'b1; tx_valid = 1'b0; return; end
        a = cyc;
        mark_word(slv, int'(div) + 1);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        t = 0;
        while (rx_valid !== 1'b1 && t < 5000) begin
            if (t == chg_at) clk_div = chg_div;
            @(posedge clock); #1; t++;
        end
        if (rx_valid !== 1'b1) begin tmo = 1'b1; return; end
        lat = cyc - a;
        rx = rx_data;
        mosi_w = mosi_hist[7:0];
        rises = rise_total - rise_base;
        bad = bad_total - bad_base;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (spi_sclk !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
        tests_run++; if (spi_mosi !== 1'b1) begin tests_failed++; $display("FAIL reset_mosi: got %b expected 1", spi_mosi); end
        tests_run++; if (spi_cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_tx_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_basic_div0();
        logic [7:0] rx, mw; int lat, rises, bad; bit tmo;
        send_word(8'hA5, 8'd0, 8'hFF, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo) begin tests_failed++; $display("FAIL basic_timeout: got timeout expected rx_valid"); end
        tests_run++; if (lat != 17) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        tests_run++; if (rx !== 8'hFF) begin tests_failed++; $display("FAIL basic_rx: got %h expected ff", rx); end
        tests_run++; if (mw !== 8'hA5) begin tests_failed++; $display("FAIL basic_mosi: got %h expected a5", mw); end
        tests_run++; if (rises != 8 || bad != 0) begin tests_failed++; $display("FAIL basic_sclk: got %0d rises %0d bad runs expected 8 rises 0 bad", rises, bad); end
        @(posedge clock); #1;
        tests_run++; if (rx_valid !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_after: got rx_valid=%b busy=%b tx_ready=%b expected 0 0 1", rx_valid, busy, tx_ready); end
    endtask

    task automatic test_div3();
        logic [7:0] rx, mw; int lat, rises, bad; bit tmo;
        send_word(8'h3C, 8'd3, 8'hC3, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo || lat != 65) begin tests_failed++; $display("FAIL div3_latency: got %0d (timeout=%0d) expected 65", lat, tmo); end
        tests_run++; if (rx !== 8'hC3) begin tests_failed++; $display("FAIL div3_rx: got %h expected c3", rx); end
        tests_run++; if (mw !== 8'h3C) begin tests_failed++; $display("FAIL div3_mosi: got %h expected 3c", mw); end
        tests_run++; if (rises != 8 || bad != 0) begin tests_failed++; $display("FAIL div3_sclk: got %0d rises %0d bad runs expected 8 rises 0 bad", rises, bad); end
        @(posedge clock); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL div3_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_random_words();
        logic [7:0] rx, mw, tx, slv, div; int lat, rises, bad; bit tmo;
        for (int i = 0; i < 6; i++) begin
            tx  = 8'($urandom);
            slv = 8'($urandom);
            div = 8'($urandom_range(0, 4));
            send_word(tx, div, slv, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
            tests_run++; if (tmo || lat != 16 * (int'(div) + 1) + 1) begin tests_failed++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, 16 * (int'(div) + 1) + 1); end
            tests_run++; if (rx !== slv) begin tests_failed++; $display("FAIL rand_rx[%0d]: got %h expected %h", i, rx, slv); end
            tests_run++; if (mw !== tx || bad != 0) begin tests_failed++; $display("FAIL rand_mosi[%0d]: got %h (bad runs %0d) expected %h (0)", i, mw, bad, tx); end
        end
    endtask

    task automatic test_back_to_back();
        int t, a2, r1, pulses;
        logic [7:0] slv1, slv2;
        slv1 = 8'($urandom); slv2 = 8'($urandom);
        pulses = 0;
        tx_valid = 1'b1; tx_data = 8'h01; clk_div = 8'd1;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        mark_word(slv1, 2);
        @(posedge clock); #1;
        tx_data = 8'h80;
        t = 0;
        while (rx_valid !== 1'b1 && t < 500) begin @(posedge clock); #1; t++; end
        if (rx_valid === 1'b1) pulses++;
        r1 = cyc;
        tests_run++; if (rx_data !== slv1 || mosi_hist[7:0] !== 8'h01) begin tests_failed++; $display("FAIL b2b_word1: got rx %h mosi %h expected rx %h mosi 01", rx_data, mosi_hist[7:0], slv1); end
        tests_run++; if (spi_sclk !== 1'b0) begin tests_failed++; $display("FAIL b2b_sclk_done: got %b expected 0", spi_sclk); end
        @(posedge clock); #1;
        tests_run++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || spi_sclk !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got rx_valid=%b tx_ready=%b sclk=%b expected 0 1 0", rx_valid, tx_ready, spi_sclk); end
        a2 = cyc;
        mark_word(slv2, 2);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        tests_run++; if (a2 != r1 + 1 || busy !== 1'b1 || tx_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_accept: got busy=%b tx_ready=%b expected 1 0", busy, tx_ready); end
        t = 0;
        while (rx_valid !== 1'b1 && t < 500) begin @(posedge clock); #1; t++; end
        if (rx_valid === 1'b1) pulses++;
        tests_run++; if (cyc - a2 != 33) begin tests_failed++; $display("FAIL b2b_latency2: got %0d expected 33", cyc - a2); end
        tests_run++; if (rx_data !== slv2 || mosi_hist[7:0] !== 8'h80) begin tests_failed++; $display("FAIL b2b_word2: got rx %h mosi %h expected rx %h mosi 80", rx_data, mosi_hist[7:0], slv2); end
        tests_run++; if (pulses != 2 || (rise_total - rise_base) != 8 || (bad_total - bad_base) != 0) begin tests_failed++; $display("FAIL b2b_pulses: got %0d pulses %0d rises %0d bad expected 2 8 0", pulses, rise_total - rise_base, bad_total - bad_base); end
    endtask

    task automatic test_div_change();
        logic [7:0] rx, mw, slv; int lat, rises, bad; bit tmo;
        slv = 8'($urandom);
        send_word(8'h6E, 8'd2, slv, 5, 8'd7, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo || lat != 49 || bad != 0) begin tests_failed++; $display("FAIL divchg_first: got lat %0d bad %0d expected 49 0", lat, bad); end
        tests_run++; if (rx !== slv || mw !== 8'h6E) begin tests_failed++; $display("FAIL divchg_first_data: got rx %h mosi %h expected %h 6e", rx, mw, slv); end
        slv = 8'($urandom);
        send_word(8'h9B, 8'd7, slv, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo || lat != 129 || bad != 0) begin tests_failed++; $display("FAIL divchg_second: got lat %0d bad %0d expected 129 0", lat, bad); end
        tests_run++; if (rx !== slv || mw !== 8'h9B) begin tests_failed++; $display("FAIL divchg_second_data: got rx %h mosi %h expected %h 9b", rx, mw, slv); end
    endtask

    task automatic test_reset_mid_transfer();
        int t, rises, late_pulses, lat, r2, bad;
        logic prev;
        logic [7:0] rx, mw; bit tmo;
        cs_assert = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hB7; clk_div = 8'd1;
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        mark_word(8'h00, 2);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        rises = 0; prev = spi_sclk; t = 0;
        while (rises < 5 && t < 500) begin
            @(posedge clock); #1; t++;
            if (spi_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = spi_sclk;
        end
        tests_run++; if (rises != 5 || rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_reach: got %0d rises rx_valid=%b expected 5 0", rises, rx_valid); end
        reset = 1'b1;
        @(posedge clock); #1;
        tests_run++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b1 || spi_cs_n !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pads: got sclk=%b mosi=%b cs_n=%b expected 0 1 1", spi_sclk, spi_mosi, spi_cs_n); end
        tests_run++; if (busy !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl: got busy=%b rx_valid=%b tx_ready=%b expected 0 0 0", busy, rx_valid, tx_ready); end
        reset = 1'b0;
        late_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (rx_valid === 1'b1) late_pulses++;
        end
        tests_run++; if (late_pulses != 0 || spi_cs_n !== 1'b0) begin tests_failed++; $display("FAIL rstmid_quiet: got %0d rx_valid pulses cs_n=%b expected 0 0", late_pulses, spi_cs_n); end
        r2 = 0;
        send_word(8'h55, 8'd1, 8'hAA, -1, 8'd0, rx, lat, mw, r2, bad, tmo);
        tests_run++; if (tmo || lat != 33 || rx !== 8'hAA || mw !== 8'h55 || r2 != 8) begin tests_failed++; $display("FAIL rstmid_recover: got lat %0d rx %h mosi %h rises %0d expected 33 aa 55 8", lat, rx, mw, r2); end
        cs_assert = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_chip_select();
        logic [7:0] rx, mw; int lat, rises, bad; bit tmo;
        cs_assert = 1'b1;
        tests_run++; if (spi_cs_n !== 1'b1) begin tests_failed++; $display("FAIL cs_latency_assert: got %b expected 1", spi_cs_n); end
        @(posedge clock); #1;
        tests_run++; if (spi_cs_n !== 1'b0) begin tests_failed++; $display("FAIL cs_assert: got %b expected 0", spi_cs_n); end
        send_word(8'h4D, 8'd0, 8'h12, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo || rx !== 8'h12 || spi_cs_n !== 1'b0) begin tests_failed++; $display("FAIL cs_transfer: got rx %h cs_n %b expected 12 0", rx, spi_cs_n); end
        cs_assert = 1'b0;
        tests_run++; if (spi_cs_n !== 1'b0) begin tests_failed++; $display("FAIL cs_latency_release: got %b expected 0", spi_cs_n); end
        @(posedge clock); #1;
        tests_run++; if (spi_cs_n !== 1'b1) begin tests_failed++; $display("FAIL cs_release: got %b expected 1", spi_cs_n); end
    endtask

`ifdef SD_SPI_ENGINE_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] rx, mw; int lat, rises, bad; bit tmo;
        loopback = 1'b1;
        cs_assert = 1'b1;
        @(posedge clock); #1;
        send_word(8'h96, 8'd1, 8'h00, -1, 8'd0, rx, lat, mw, rises, bad, tmo);
        tests_run++; if (tmo || rx !== 8'h96) begin tests_failed++; $display("FAIL loopback_rx: got %h expected 96", rx); end
        tests_run++; if (spi_cs_n !== 1'b1) begin tests_failed++; $display("FAIL loopback_cs_n: got %b expected 1", spi_cs_n); end
        loopback = 1'b0;
        cs_assert = 1'b0;
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_div0();
        test_div3();
        test_random_words();
        test_back_to_back();
        test_div_change();
        test_reset_mid_transfer();
        test_chip_select();
`ifdef SD_SPI_ENGINE_LOOPBACK_EN
        test_loopback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sd_spi_engine.md
Name: sd_spi_engine

Overview:
- Byte-serial SPI master shift engine that sits directly below the SPI peripheral's register file, in the SD-card path at 0x60020000.
- The register file hands it transmit words and chip-select intent; the engine drives SCLK/MOSI/CS, samples MISO, and returns each received word.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, runtime-programmable clock divider.

Parameters:
- DATA_W, 8, bits per transfer word
- DIV_W, 8, width of clk_div input

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 clock cycles; latched at word accept
- cs_assert  in  1  register-file chip-select request (1 = select card)
- tx_valid  in  1  transmit word offered
- tx_ready  out  1  engine can accept a word
- tx_data  in  DATA_W  word to shift out
- rx_valid  out  1  one-cycle pulse: rx_data holds a completed received word
- rx_data  out  DATA_W  last received word; held until the next completion
- busy  out  1  transfer in progress
- spi_sclk  out  1  SPI clock to pad
- spi_mosi  out  1  SPI data out to pad
- spi_miso  in  1  SPI data in from pad (pre-synchronised by the pad wrapper)
- spi_cs_n  out  1  active-low chip select to pad

Behaviour:
- Reset values (all outputs registered): tx_ready=1 after reset deasserts, rx_valid=0, rx_data=0, busy=0, spi_sclk=0, spi_mosi=1, spi_cs_n=1. While reset is asserted, tx_ready=0.
- spi_cs_n is ~cs_assert, registered with 1-cycle latency, independent of the FSM. Deasserting cs_assert mid-word does not abort the word.
- States:
  - IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data into shift_reg, clk_div into div_q; bitcnt=DATA_W; go to LOW.
  - LOW: sclk=0, mosi=shift_reg[MSB]. After div_q+1 cycles, raise sclk, sample miso into rx_shift LSB, go to HIGH.
  - HIGH: sclk=1. After div_q+1 cycles, lower sclk and decrement bitcnt. If bitcnt becomes 0, go to DONE; else shift shift_reg left and go to LOW (MOSI changes on the falling edge).
  - DONE: rx_data<=rx_shift, rx_valid=1 for exactly one cycle, mosi=1. Next state is IDLE.
- Latency: accept cycle A; rx_valid asserts at cycle A + 2*DATA_W*(div_q+1) + 1. tx_ready reasserts the cycle after rx_valid.
- busy=1 from the cycle after accept through the DONE cycle.
- Half-period counter is DIV_W wide and counts div_q down to 0; clk_div=0 gives SCLK = clock/2. clk_div=2^DIV_W−1 must not overflow.
- No rx backpressure: the consumer must take rx_data in the rx_valid cycle. rx_data stays stable until the next DONE.
- A tx_valid held during busy is ignored until IDLE; tx_data need not be stable after accept.
- Reset mid-transfer returns to IDLE on the next edge with all reset values. No partial rx_valid is produced.

Optional Feature:
- Macro: SD_SPI_ENGINE_LOOPBACK_EN.
- When defined: extra input loopback (1 bit). When loopback=1, MISO sampling uses internal spi_mosi instead of the spi_miso pin, and spi_cs_n is forced to 1 so the card stays deselected. Used for bring-up self-test.
- When undefined: no loopback port; sampling always uses spi_miso.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, LOW, HIGH, DONE), SPI_DATA_W=8, SPI_DIV_W=8, reset constants for pad outputs.
- One natural sub-module: spi_half_period_timer (load/count/expire pulse), reused by later SPI variants. Everything else stays in sd_spi_engine.

Test Plan:
- Reset then clk_div=0, send 0xA5 with miso tied to 1 -> MOSI 1,0,1,0,0,1,0,1 on rising edges; 8 SCLK pulses of 2-cycle period; rx_valid exactly 17 cycles after accept, rx_data=0xFF.
- clk_div=3, send 0x3C, bench drives 0xC3 on miso (mode 0) -> SCLK high/low 4 cycles each; rx_data=0xC3 at accept+65; busy low the next cycle.
- Back-to-back: tx_valid held high with 0x01 then 0x80 -> second accept occurs the cycle after the first rx_valid; two rx_valid pulses; no SCLK glitch between words.
- clk_div changed 2->7 mid-word -> current word keeps half-period 3; the next word uses 8.
- Reset asserted at the 5th SCLK rising edge -> next cycle sclk=0, mosi=1, cs_n=1, busy=0, no rx_valid; a following 0x55 transfer completes normally.
- cs_assert 0->1->0 around one transfer -> spi_cs_n follows with 1-cycle delay. With SD_SPI_ENGINE_LOOPBACK_EN and loopback=1, sending 0x96 -> rx_data=0x96 and cs_n stays 1.
